// File: rtl/frame_sweep_ctrl_pkg.sv
// Shared definitions for the frame sweep sequencer.
// Holds the controller state encoding, the filter mode codes handed to the
// kernel, and the default frame geometry.
package frame_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_BLUR    = 2'b00;
    localparam logic [1:0] MODE_SHARPEN = 2'b01;
    localparam logic [1:0] MODE_OUTLINE = 2'b10;
    localparam logic [1:0] MODE_EMBOSS  = 2'b11;

    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;

endpackage

// File: rtl/frame_sweep_ctrl_pixel_coord_tracker.sv
// pixel_coord_tracker: keeps the linear pixel index together with its
// row/column so border and last-pixel tests are simple compares.
// Ports:
//   clk, n_rst   clock, synchronous active-low reset
//   clear        restart at pixel 0 (row 0, col 0)
//   advance      step to the next pixel in raster order
//   pix          current pixel index (ADDR_W+1 bits)
//   border       current pixel lies on the frame border
//   next_border  the pixel after the current one lies on the border
//   last         current pixel is IMG_W*IMG_H-1
module pixel_coord_tracker #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W:0]   pix,
    output logic              border,
    output logic              next_border,
    output logic              last
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   COL_PEN  = CW'(IMG_W - 2);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W+1)'(IMG_W * IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            pix <= '0;
            col <= '0;
            row <= '0;
        end else if (advance) begin
            pix <= pix + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    // Successor wraps to col 0 when on the last column; otherwise same row,
    // and it hits the right edge when we are on the penultimate column.
    assign next_border = (row == '0) || (row == ROW_LAST) || (col == COL_LAST) ||
                         ((IMG_W >= 2) && (col == COL_PEN));
    assign last = (pix == PIX_LAST);

endmodule

// File: rtl/frame_sweep_ctrl.sv
// frame_sweep_ctrl: walks the kernel_ops datapath over every pixel of a
// frame, waits for each result (with a per-pixel timeout) and writes it
// to the output frame buffer at the pixel's address.
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   start, abort, mode_in   frame control; mode latched at start
//   k_pixel, k_mode,
//   k_strobe                request to kernel (strobe marks a new pixel)
//   k_result, k_output      kernel result pulse and data
//   wr_en, wr_addr, wr_data,
//   wr_ready                output buffer write handshake
//   busy, done, timeout_err status
// Build option: define FRAME_SEQ_BORDER_SKIP_EN to bypass the kernel for
// border pixels and write 0 there instead.
module frame_sweep_ctrl
    import frame_sweep_ctrl_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 17,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode_in,
    output logic [ADDR_W:0]   k_pixel,
    output logic [1:0]        k_mode,
    output logic              k_strobe,
    input  logic              k_result,
    input  logic [DATA_W-1:0] k_output,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [ADDR_W:0] pix, pix_next;
    logic            border, next_border, last;
    logic            clear, advance, expire;
    logic [WCW-1:0]  wcnt;
    logic            unused_border;

    pixel_coord_tracker #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_coord (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .advance     (advance),
        .pix         (pix),
        .border      (border),
        .next_border (next_border),
        .last        (last)
    );

    // Current-pixel border flag is informational only; decisions are made
    // on the successor when advancing.
    assign unused_border = border ^ next_border;

    // wcnt counts WAIT cycles from 0, so expiry lands on the TIMEOUT-th one.
    assign expire = (wcnt == WCNT_LAST);

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                clear = 1'b1;
`ifdef FRAME_SEQ_BORDER_SKIP_EN
                state_nxt = S_WRITE;      // pixel 0 is always on the border
`else
                state_nxt = S_ISSUE;
`endif
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (k_result || expire) state_nxt = S_WRITE;
            S_WRITE: if (wr_ready) begin
                if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    advance = 1'b1;
`ifdef FRAME_SEQ_BORDER_SKIP_EN
                    state_nxt = next_border ? S_WRITE : S_ISSUE;
`else
                    state_nxt = S_ISSUE;
`endif
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            clear     = 1'b0;
            advance   = 1'b0;
        end
        pix_next = pix;
        if (clear)        pix_next = '0;
        else if (advance) pix_next = pix + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            k_pixel     <= '0;
            k_mode      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!abort) begin
                if (state == S_IDLE && start) begin
                    k_mode      <= mode_in;
                    timeout_err <= 1'b0;
                end
                // k_pixel/wr_addr load on entry so they are valid during ISSUE
                if (state_nxt == S_ISSUE) begin
                    k_pixel <= pix_next;
                    wr_addr <= pix_next[ADDR_W-1:0];
                end
                if (state == S_ISSUE) wcnt <= '0;
                if (state == S_WAIT) begin
                    wcnt <= wcnt + 1'b1;
                    if (k_result) begin
                        wr_data <= k_output;
                    end else if (expire) begin
                        wr_data     <= '0;
                        timeout_err <= 1'b1;
                    end
                end
`ifdef FRAME_SEQ_BORDER_SKIP_EN
                // Border pixel entered straight from IDLE or a prior WRITE.
                if (state_nxt == S_WRITE && (clear || advance)) begin
                    wr_addr <= pix_next[ADDR_W-1:0];
                    wr_data <= '0;
                end
`endif
            end
        end
    end

    assign k_strobe = (state == S_ISSUE);
    assign wr_en    = (state == S_WRITE);
    assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WRITE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_frame_sweep_ctrl.sv
module tb_frame_sweep_ctrl;
    import frame_sweep_ctrl_pkg::*;

    localparam int IMG_W = 4, IMG_H = 4, ADDR_W = 4, DATA_W = 17, TIMEOUT = 8;
    localparam int NPIX = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              n_rst, start, abort, k_result, wr_ready;
    logic [1:0]        mode_in, k_mode;
    logic [ADDR_W:0]   k_pixel;
    logic              k_strobe, wr_en, busy, done, timeout_err;
    logic [DATA_W-1:0] k_output, wr_data;
    logic [ADDR_W-1:0] wr_addr;

    logic              kres_model, kres_stray;
    logic [DATA_W-1:0] kout_model, kout_stray;
    assign k_result = kres_model | kres_stray;
    assign k_output = kres_stray ? kout_stray : kout_model;

    always #5 clk = ~clk;

    frame_sweep_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode_in(mode_in),
        .k_pixel(k_pixel), .k_mode(k_mode), .k_strobe(k_strobe),
        .k_result(k_result), .k_output(k_output),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // Kernel behaviour: kdelay[p] cycles after the strobe for pixel p it
    // pulses k_result with kbase+p; a delay of 0 means it never answers.
    int                kdelay [NPIX];
    logic [DATA_W-1:0] kbase;
    int                stall_gen = 0;
    int                stall_addr = 0;

    initial begin : kernel
        int p;
        int d;
        kres_model = 1'b0;
        kout_model = '0;
        forever begin
            @(negedge clk);
            if (k_strobe === 1'b1) begin
                p = int'(k_pixel);
                d = (p < NPIX) ? kdelay[p] : 0;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1 kres_model = 1'b1;
                    kout_model = kbase + DATA_W'(p);
                    @(posedge clk);
                    #1 kres_model = 1'b0;
                    kout_model = '0;
                end
            end
        end
    end

    // Output buffer: holds wr_ready low for 3 cycles on stall_addr once per
    // arming (stall_gen bump).
    initial begin : buffer
        int seen;
        int left;
        seen = 0;
        left = 0;
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_gen != seen) begin
                seen = stall_gen;
                left = 3;
            end
            if (wr_en === 1'b1 && int'(wr_addr) == stall_addr && left > 0) begin
                wr_ready = 1'b0;
                left--;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    // Observer: records strobes, accepted writes, done pulses, write hold stability.
    typedef struct { int addr; int data; int hold; int lat; } wr_rec_t;
    wr_rec_t wq [$];
    int      sq_pix [$];
    int      sq_mode [$];
    int      done_cnt = 0;
    int      unstable = 0;

    initial begin : monitor
        int cyc, strobe_cyc, en_cyc, first_en;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        cyc = 0; strobe_cyc = 0; en_cyc = 0; first_en = 0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (k_strobe === 1'b1) begin
                sq_pix.push_back(int'(k_pixel));
                sq_mode.push_back(int'(k_mode));
                strobe_cyc = cyc;
            end
            if (done === 1'b1) done_cnt++;
            if (wr_en === 1'b1) begin
                if (en_cyc == 0) first_en = cyc;
                else if (wr_addr !== pa || wr_data !== pd) unstable++;
                en_cyc++;
                pa = wr_addr;
                pd = wr_data;
                if (wr_ready === 1'b1) begin
                    wq.push_back('{addr: int'(wr_addr), data: int'(wr_data),
                                   hold: en_cyc, lat: first_en - strobe_cyc});
                    en_cyc = 0;
                end
            end else begin
                en_cyc = 0;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_border(input int p);
`ifdef FRAME_SEQ_BORDER_SKIP_EN
        int r;
        int c;
        r = p / IMG_W;
        c = p % IMG_W;
        return (r == 0) || (r == IMG_H - 1) || (c == 0) || (c == IMG_W - 1);
`else
        return 1'b0 & p[0];
`endif
    endfunction

    function automatic bit answered(input int p);
        return kdelay[p] >= 1 && kdelay[p] <= TIMEOUT;
    endfunction

    function automatic int exp_data(input int p);
        logic [DATA_W-1:0] v;
        v = kbase + DATA_W'(p);
        if (is_border(p) || !answered(p)) return 0;
        return int'(v);
    endfunction

    task automatic set_delays(input int lo, input int hi);
        for (int p = 0; p < NPIX; p++) kdelay[p] = $urandom_range(hi, lo);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1 start = 1'b1; mode_in = m;
        @(posedge clk); #1 start = 1'b0; mode_in = ~m;
    endtask

    // Full frame with expectations derived from kdelay/kbase; stall=1 means
    // the write at stall_addr is expected to be held for 4 cycles.
    task automatic run_frame(input logic [1:0] m, input string tag, input bit stall);
        int w0, s0, d0, n, e_to;
        int exp_pix [$];
        bit got;
        w0 = wq.size(); s0 = sq_pix.size(); d0 = done_cnt;
        pulse_start(m);
        @(negedge clk);
        check({tag, "/to_clr"}, timeout_err, 0);
        check({tag, "/strobe_t1"}, k_strobe, is_border(0) ? 0 : 1);
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        check({tag, "/done_seen"}, got, 1);
        check({tag, "/busy_at_done"}, busy, 0);
        repeat (2) @(negedge clk);
        check({tag, "/done_cnt"}, done_cnt - d0, 1);
        n = wq.size() - w0;
        check({tag, "/nwrites"}, n, NPIX);
        e_to = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (!is_border(p)) begin
                exp_pix.push_back(p);
                if (!answered(p)) e_to = 1;
            end
        end
        for (int i = 0; i < n && i < NPIX; i++) begin
            check($sformatf("%s/addr%0d", tag, i), wq[w0+i].addr, i);
            check($sformatf("%s/data%0d", tag, i), wq[w0+i].data, exp_data(i));
            check($sformatf("%s/hold%0d", tag, i), wq[w0+i].hold,
                  (stall && i == stall_addr) ? 4 : 1);
            if (!is_border(i))
                check($sformatf("%s/lat%0d", tag, i), wq[w0+i].lat,
                      answered(i) ? kdelay[i] + 1 : TIMEOUT + 1);
        end
        check({tag, "/nstrobes"}, sq_pix.size() - s0, exp_pix.size());
        for (int i = 0; i < exp_pix.size() && s0 + i < sq_pix.size(); i++) begin
            check($sformatf("%s/spix%0d", tag, i), sq_pix[s0+i], exp_pix[i]);
            check($sformatf("%s/smode%0d", tag, i), sq_mode[s0+i], m);
        end
        check({tag, "/timeout_err"}, timeout_err, e_to);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0, d0, u0;
        bit got;
        logic [1:0] m;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; mode_in = 2'b00;
        kres_stray = 1'b0; kout_stray = '0; kbase = '0;
        for (int p = 0; p < NPIX; p++) kdelay[p] = 2;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/k_pixel", k_pixel, 0);
        check("rst/k_mode", k_mode, 0);
        check("rst/k_strobe", k_strobe, 0);
        check("rst/wr_en", wr_en, 0);
        check("rst/wr_addr", wr_addr, 0);
        check("rst/wr_data", wr_data, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/timeout_err", timeout_err, 0);
        @(posedge clk); #1 n_rst = 1'b1;

        // Baseline frame: outline mode, kernel answers 2 cycles after strobe
        kbase = 17'h100;
        run_frame(MODE_OUTLINE, "base", 1'b0);

        // Silent kernel on pixel 5, result coinciding with expiry on pixel 6
        set_delays(1, TIMEOUT - 1);
        kdelay[5] = 0;
        kdelay[6] = TIMEOUT;
        kbase = DATA_W'($urandom);
        m = 2'($urandom_range(3, 0));
        run_frame(m, "tmo", 1'b0);

        // Stray result while idle: no write, sticky error kept
        w0 = wq.size();
        @(posedge clk); #1 kres_stray = 1'b1; kout_stray = DATA_W'($urandom);
        @(posedge clk); #1 kres_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray/nwrites", wq.size() - w0, 0);
        check("stray/busy", busy, 0);
        check("stray/timeout_err", timeout_err, 1);

        // Write back-pressure on address 7; start must clear timeout_err
        set_delays(1, TIMEOUT);
        kbase = DATA_W'($urandom);
        stall_addr = 7;
        stall_gen++;
        u0 = unstable;
        run_frame(MODE_BLUR, "stall", 1'b1);
        check("stall/stable", unstable - u0, 0);

        // Abort during WAIT of pixel 9, after pixel 5 timed out
        set_delays(1, TIMEOUT);
        kdelay[5] = 0;
        kdelay[9] = 2;
        w0 = wq.size(); d0 = done_cnt;
        pulse_start(MODE_EMBOSS);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (k_strobe === 1'b1 && int'(k_pixel) == 9) begin got = 1'b1; break; end
        end
        check("abort/reach_p9", got, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort/busy", busy, 0);
        check("abort/wr_en", wr_en, 0);
        check("abort/k_strobe", k_strobe, 0);
        repeat (6) @(negedge clk);
        check("abort/no_done", done_cnt - d0, 0);
        check("abort/nwrites", wq.size() - w0, 9);
        check("abort/timeout_err", timeout_err, 1);
        check("abort/idle", busy, 0);

        // Restart from pixel 0 after the abort
        set_delays(1, TIMEOUT);
        kbase = DATA_W'($urandom);
        m = 2'($urandom_range(3, 0));
        run_frame(m, "restart", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
